// File: rtl/id_stage_p_pkg.sv
// Opcode, function, ALU-op and result-select constants for the decode stage,
// plus the combinational instruction decoder shared by the ID stage.
package id_stage_p_pkg;

   localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
   localparam logic [5:0] EXE_ANDI         = 6'b001100;
   localparam logic [5:0] EXE_ORI          = 6'b001101;
   localparam logic [5:0] EXE_XORI         = 6'b001110;
   localparam logic [5:0] EXE_LUI          = 6'b001111;
   localparam logic [5:0] EXE_PREF         = 6'b110011;

   localparam logic [5:0] EXE_SLL  = 6'b000000;
   localparam logic [5:0] EXE_SRL  = 6'b000010;
   localparam logic [5:0] EXE_SRA  = 6'b000011;
   localparam logic [5:0] EXE_SLLV = 6'b000100;
   localparam logic [5:0] EXE_SRLV = 6'b000110;
   localparam logic [5:0] EXE_SRAV = 6'b000111;
   localparam logic [5:0] EXE_MOVZ = 6'b001010;
   localparam logic [5:0] EXE_MOVN = 6'b001011;
   localparam logic [5:0] EXE_SYNC = 6'b001111;
   localparam logic [5:0] EXE_MFHI = 6'b010000;
   localparam logic [5:0] EXE_MTHI = 6'b010001;
   localparam logic [5:0] EXE_MFLO = 6'b010010;
   localparam logic [5:0] EXE_MTLO = 6'b010011;
   localparam logic [5:0] EXE_AND  = 6'b100100;
   localparam logic [5:0] EXE_OR   = 6'b100101;
   localparam logic [5:0] EXE_XOR  = 6'b100110;
   localparam logic [5:0] EXE_NOR  = 6'b100111;

   localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
   localparam logic [7:0] EXE_MOVZ_OP = 8'b00001010;
   localparam logic [7:0] EXE_MOVN_OP = 8'b00001011;
   localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP = 8'b00010011;

   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
   localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic        re1;
      logic        re2;
      logic        wreg;
      logic        wd_rt;
      logic        movn;
      logic        movz;
      logic        invalid;
      logic [31:0] imm;
   } dec_t;

   function automatic dec_t mk(input logic [7:0] op, input logic [2:0] sel,
                               input logic r1, input logic r2, input logic we);
      dec_t d;
      d        = '0;
      d.aluop  = op;
      d.alusel = sel;
      d.re1    = r1;
      d.re2    = r2;
      d.wreg   = we;
      return d;
   endfunction

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t d;
      d         = '0;
      d.invalid = 1'b1;
      case (inst[31:26])
         EXE_SPECIAL_INST: begin
            if (inst[10:6] == 5'd0) begin
               case (inst[5:0])
                  EXE_OR:   d = mk(EXE_OR_OP,  EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1);
                  EXE_AND:  d = mk(EXE_AND_OP, EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1);
                  EXE_XOR:  d = mk(EXE_XOR_OP, EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1);
                  EXE_NOR:  d = mk(EXE_NOR_OP, EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1);
                  EXE_SLLV: d = mk(EXE_SLL_OP, EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1);
                  EXE_SRLV: d = mk(EXE_SRL_OP, EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1);
                  EXE_SRAV: d = mk(EXE_SRA_OP, EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1);
                  EXE_MOVN: begin
                     d      = mk(EXE_MOVN_OP, EXE_RES_MOVE, 1'b1, 1'b1, 1'b0);
                     d.movn = 1'b1;
                  end
                  EXE_MOVZ: begin
                     d      = mk(EXE_MOVZ_OP, EXE_RES_MOVE, 1'b1, 1'b1, 1'b0);
                     d.movz = 1'b1;
                  end
                  EXE_SYNC: d = mk(EXE_NOP_OP,  EXE_RES_NOP,  1'b0, 1'b1, 1'b0);
                  EXE_MFHI: d = mk(EXE_MFHI_OP, EXE_RES_MOVE, 1'b0, 1'b0, 1'b1);
                  EXE_MFLO: d = mk(EXE_MFLO_OP, EXE_RES_MOVE, 1'b0, 1'b0, 1'b1);
                  EXE_MTHI: d = mk(EXE_MTHI_OP, EXE_RES_NOP,  1'b1, 1'b0, 1'b0);
                  EXE_MTLO: d = mk(EXE_MTLO_OP, EXE_RES_NOP,  1'b1, 1'b0, 1'b0);
                  default: ;
               endcase
            end
            // Constant shifts carry shamt into operand 1 in place of a register read.
            if (inst[25:21] == 5'd0) begin
               case (inst[5:0])
                  EXE_SLL: d = mk(EXE_SLL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1);
                  EXE_SRL: d = mk(EXE_SRL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1);
                  EXE_SRA: d = mk(EXE_SRA_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1);
                  default: ;
               endcase
               if (inst[5:0] == EXE_SLL || inst[5:0] == EXE_SRL || inst[5:0] == EXE_SRA)
                  d.imm = {27'h0, inst[10:6]};
            end
         end
         EXE_ORI, EXE_ANDI, EXE_XORI: begin
            d = mk((inst[31:26] == EXE_ORI)  ? EXE_OR_OP :
                   (inst[31:26] == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP,
                   EXE_RES_LOGIC, 1'b1, 1'b0, 1'b1);
            d.wd_rt = 1'b1;
            d.imm   = {16'h0, inst[15:0]};
         end
         EXE_LUI: begin
            d       = mk(EXE_OR_OP, EXE_RES_LOGIC, 1'b1, 1'b0, 1'b1);
            d.wd_rt = 1'b1;
            d.imm   = {inst[15:0], 16'h0};
         end
         EXE_PREF: d = mk(EXE_NOP_OP, EXE_RES_NOP, 1'b0, 1'b0, 1'b0);
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_stage_p_operand_fwd.sv
// One read port: zero register, priority forwarding (index 0 youngest), register file,
// or immediate when the port is not read; flags a hazard on a pending highest-priority match.
module id_operand_fwd #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                      re,
   input  logic [REG_AW-1:0]         raddr,
   input  logic [DATA_W-1:0]         rf_rdata,
   input  logic [DATA_W-1:0]         imm,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   output logic [DATA_W-1:0]         data,
   output logic                      hazard
);

   always_comb begin
      data   = rf_rdata;
      hazard = 1'b0;
      if (!re) begin
         data = imm;
      end else if (raddr == '0) begin
         data = '0;
      end else begin
         // Walk oldest to youngest so the lowest-index match is the one that sticks.
         for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == raddr) begin
               data   = fwd_wdata[i*DATA_W +: DATA_W];
               hazard = fwd_pending[i];
            end
         end
      end
   end

endmodule

// File: rtl/id_stage_p.sv
// Registered ID stage: decodes, resolves operands through forwarding, stalls on load-use.
// One cycle accept-to-out_valid; output holds while !out_ready, flush kills it.
module id_stage_p #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               pc_i,
   input  logic [31:0]               inst_i,
   output logic                      rf_re1,
   output logic                      rf_re2,
   output logic [REG_AW-1:0]         rf_raddr1,
   output logic [REG_AW-1:0]         rf_raddr2,
   input  logic [DATA_W-1:0]         rf_rdata1,
   input  logic [DATA_W-1:0]         rf_rdata2,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_pc,
   output logic [7:0]                aluop_o,
   output logic [2:0]                alusel_o,
   output logic [DATA_W-1:0]         reg1_o,
   output logic [DATA_W-1:0]         reg2_o,
   output logic [REG_AW-1:0]         wd_o,
   output logic                      wreg_o,
   output logic                      inst_invalid_o,
   output logic [31:0]               stall_cnt_o
);

   import id_stage_p_pkg::*;

   dec_t              dec;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] reg1_d;
   logic [DATA_W-1:0] reg2_d;
   logic              haz1;
   logic              haz2;
   logic              hazard;
   logic              wreg_d;
   logic              accept;

   assign dec       = decode(inst_i);
   assign imm       = DATA_W'(dec.imm);
   assign rf_re1    = dec.re1;
   assign rf_re2    = dec.re2;
   assign rf_raddr1 = REG_AW'(inst_i[25:21]);
   assign rf_raddr2 = REG_AW'(inst_i[20:16]);

   id_operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd1 (
      .re(dec.re1), .raddr(rf_raddr1), .rf_rdata(rf_rdata1), .imm(imm),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .fwd_pending(fwd_pending), .data(reg1_d), .hazard(haz1)
   );

   id_operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd2 (
      .re(dec.re2), .raddr(rf_raddr2), .rf_rdata(rf_rdata2), .imm(imm),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .fwd_pending(fwd_pending), .data(reg2_d), .hazard(haz2)
   );

   // Conditional moves decide write-back on the fully forwarded rt value.
   always_comb begin
      wreg_d = dec.wreg;
      if (dec.movn)
         wreg_d = (reg2_d != '0);
      else if (dec.movz)
         wreg_d = (reg2_d == '0);
   end

   assign hazard   = in_valid && (haz1 || haz2);
   assign in_ready = flush || (!hazard && (!out_valid || out_ready));
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid      <= 1'b0;
         out_pc         <= '0;
         aluop_o        <= '0;
         alusel_o       <= '0;
         reg1_o         <= '0;
         reg2_o         <= '0;
         wd_o           <= '0;
         wreg_o         <= 1'b0;
         inst_invalid_o <= 1'b0;
         stall_cnt_o    <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid      <= 1'b1;
            out_pc         <= pc_i;
            aluop_o        <= dec.aluop;
            alusel_o       <= dec.alusel;
            reg1_o         <= reg1_d;
            reg2_o         <= reg2_d;
            wd_o           <= dec.wd_rt ? REG_AW'(inst_i[20:16]) : REG_AW'(inst_i[15:11]);
            wreg_o         <= wreg_d;
            inst_invalid_o <= dec.invalid;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (hazard && !flush && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboarded bench for id_stage_p: directed instructions push expectations,
// a monitor pops them whenever EX consumes the output.
module tb_id_stage_p;

   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic        inv;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] pc_i = '0;
   logic [31:0] inst_i = '0;
   logic        rf_re1, rf_re2;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [1:0]  fwd_we = '0;
   logic [9:0]  fwd_waddr = '0;
   logic [63:0] fwd_wdata = '0;
   logic [1:0]  fwd_pending = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] reg1_o, reg2_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic        inst_invalid_o;
   logic [31:0] stall_cnt_o;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // Register file model: register r holds 0xA000_0000 | r.
   assign rf_rdata1 = 32'hA000_0000 | {27'h0, rf_raddr1};
   assign rf_rdata2 = 32'hA000_0000 | {27'h0, rf_raddr2};

   id_stage_p dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i), .rf_re1(rf_re1), .rf_re2(rf_re2),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .fwd_pending(fwd_pending), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .aluop_o(aluop_o),
      .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
      .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] op,
                               input logic [2:0] sel, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [4:0] wd,
                               input logic wreg, input logic inv);
      exp_t e;
      e.pc = pc; e.aluop = op; e.alusel = sel; e.r1 = r1; e.r2 = r2;
      e.wd = wd; e.wreg = wreg; e.inv = inv;
      return e;
   endfunction

   task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic pend);
      fwd_we[i]            = we;
      fwd_waddr[i*5 +: 5]  = a;
      fwd_wdata[i*32 +: 32] = d;
      fwd_pending[i]       = pend;
   endtask

   task automatic clear_fwd();
      fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_pending = '0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                        input exp_t e, input bit push);
      int n;
      n        = 0;
      in_valid = 1'b1;
      pc_i     = pc;
      inst_i   = inst;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("issue_accept", {63'h0, in_ready}, 64'h1);
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         n++;
         @(posedge clk);
      end
      chk("scoreboard_drain", 64'(sb_q.size()), 64'h0);
      #1;
   endtask

   initial begin : monitor
      exp_t got, req;
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            got = {out_pc, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o};
            n_checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL unexpected_output: got %h, required no output", got);
            end else begin
               req = sb_q.pop_front();
               if (got === req) n_pass++;
               else $display("FAIL out_pc_%h: got %h, required %h", req.pc, got, req);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      #1 rst = 1'b0;
      #2;
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_stall_cnt", {32'h0, stall_cnt_o}, 64'h0);
      chk("rst_reg1", {32'h0, reg1_o}, 64'h0);
      chk("rst_wreg", {63'h0, wreg_o}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1;

      // ORI $1,$0,0x1234
      issue(32'h100, 32'h3401_1234, mk(32'h100, 8'h25, 3'd1, 32'h0, 32'h0000_1234, 5'd1, 1'b1, 1'b0), 1);
      // OR $3,$1,$2: youngest forward wins; older pending entry ignored
      set_fwd(0, 1'b1, 5'd1, 32'hAAAA_0000, 1'b0);
      set_fwd(1, 1'b1, 5'd1, 32'h0000_5555, 1'b1);
      issue(32'h104, 32'h0022_1825, mk(32'h104, 8'h25, 3'd1, 32'hAAAA_0000, 32'hA000_0002, 5'd3, 1'b1, 1'b0), 1);
      clear_fwd();
      // SLL $10,$11,4
      issue(32'h108, 32'h000B_5100, mk(32'h108, 8'h7C, 3'd2, 32'h4, 32'hA000_000B, 5'd10, 1'b1, 1'b0), 1);
      // LUI $2,0xBEEF
      issue(32'h10C, 32'h3C02_BEEF, mk(32'h10C, 8'h25, 3'd1, 32'h0, 32'hBEEF_0000, 5'd2, 1'b1, 1'b0), 1);
      // MFHI $12
      issue(32'h110, 32'h0000_6010, mk(32'h110, 8'h10, 3'd3, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0), 1);
      // OR $3,$0,$2 with a pending forward on $0: reads zero, never stalls
      set_fwd(0, 1'b1, 5'd0, 32'h0000_1234, 1'b1);
      issue(32'h114, 32'h0002_1825, mk(32'h114, 8'h25, 3'd1, 32'h0, 32'hA000_0002, 5'd3, 1'b1, 1'b0), 1);
      clear_fwd();
      drain();

      // AND $4,$5,$6 stalled three cycles on a pending load into $5
      set_fwd(1, 1'b1, 5'd5, 32'h0000_0F0F, 1'b1);
      in_valid = 1'b1; pc_i = 32'h118; inst_i = 32'h00A6_2024;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall_in_ready_%0d", c), {63'h0, in_ready}, 64'h0);
         @(posedge clk);
      end
      #1 fwd_pending = '0;
      @(negedge clk);
      chk("release_in_ready", {63'h0, in_ready}, 64'h1);
      chk("stall_cnt_3", {32'h0, stall_cnt_o}, 64'h3);
      sb_q.push_back(mk(32'h118, 8'h24, 3'd1, 32'h0000_0F0F, 32'hA000_0006, 5'd4, 1'b1, 1'b0));
      @(posedge clk);
      #1 in_valid = 1'b0;
      clear_fwd();
      @(negedge clk);
      chk("release_out_valid", {63'h0, out_valid}, 64'h1);
      @(posedge clk);
      #1;

      // MOVN $7,$8,$9 with forwarded rt = 0, then rt = 1
      set_fwd(0, 1'b1, 5'd9, 32'h0, 1'b0);
      issue(32'h11C, 32'h0109_380B, mk(32'h11C, 8'h0B, 3'd3, 32'hA000_0008, 32'h0, 5'd7, 1'b0, 1'b0), 1);
      set_fwd(0, 1'b1, 5'd9, 32'h1, 1'b0);
      issue(32'h120, 32'h0109_380B, mk(32'h120, 8'h0B, 3'd3, 32'hA000_0008, 32'h1, 5'd7, 1'b1, 1'b0), 1);
      clear_fwd();
      // Undecoded opcode 0x3F
      issue(32'h124, 32'hFC00_0000, mk(32'h124, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1), 1);
      drain();

      // Hold for two cycles, then flush with a hazarding instruction presented
      out_ready = 1'b0;
      issue(32'h200, 32'h3405_0077, mk(32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("hold_valid_%0d", c), {63'h0, out_valid}, 64'h1);
         chk($sformatf("hold_reg2_%0d", c), {32'h0, reg2_o}, 64'h77);
         chk($sformatf("hold_pc_%0d", c), {32'h0, out_pc}, 64'h200);
         chk($sformatf("hold_in_ready_%0d", c), {63'h0, in_ready}, 64'h0);
         @(posedge clk);
      end
      #1 flush = 1'b1;
      in_valid = 1'b1; pc_i = 32'h204; inst_i = 32'h00A6_2024;
      set_fwd(1, 1'b1, 5'd5, 32'h0, 1'b1);
      @(negedge clk);
      chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      clear_fwd();
      @(negedge clk);
      chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
      chk("flush_no_stall_count", {32'h0, stall_cnt_o}, 64'h3);
      @(posedge clk);
      #1;

      // Async reset in the middle of a stall
      issue(32'h300, 32'h3405_0077, mk(32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 0);
      set_fwd(1, 1'b1, 5'd5, 32'h0, 1'b1);
      in_valid = 1'b1; pc_i = 32'h304; inst_i = 32'h00A6_2024;
      @(posedge clk);
      @(posedge clk);
      #1 chk("pre_rst_stall_cnt", {32'h0, stall_cnt_o}, 64'h5);
      #2 rst = 1'b0;
      #1;
      chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("arst_stall_cnt", {32'h0, stall_cnt_o}, 64'h0);
      chk("arst_out_pc", {32'h0, out_pc}, 64'h0);
      chk("arst_reg2", {32'h0, reg2_o}, 64'h0);
      chk("arst_wd_wreg_aluop", {48'h0, wd_o, wreg_o, aluop_o, 2'b00}, 64'h0);
      in_valid = 1'b0;
      clear_fwd();
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rerelease_in_ready", {63'h0, in_ready}, 64'h1);
      chk("rerelease_out_valid", {63'h0, out_valid}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
